// File: rtl/riscv_v_rf_mp_pkg.sv
// Shared vector datapath types for the multi-port vector register file.
// Default geometry matches the baseline single-write/dual-read vector RF.
package riscv_v_rf_mp_pkg;

    localparam int unsigned RISCV_V_NUM_BYTES_DATA = 16;
    localparam int unsigned RISCV_V_DATA_W         = 8 * RISCV_V_NUM_BYTES_DATA;
    localparam int unsigned RISCV_V_NUM_REGS       = 32;
    localparam int unsigned RISCV_V_ADDR_W         = $clog2(RISCV_V_NUM_REGS);

    typedef logic [7:0] riscv_v_byte_t;

    typedef union packed {
        logic          [RISCV_V_DATA_W-1:0]         Word;
        riscv_v_byte_t [RISCV_V_NUM_BYTES_DATA-1:0] Byte;
    } riscv_v_data_t;

    typedef logic [RISCV_V_ADDR_W-1:0]         riscv_v_addr_t;
    typedef logic [RISCV_V_NUM_BYTES_DATA-1:0] riscv_v_be_t;

    // One write-port request in the default geometry.
    typedef struct packed {
        logic          valid;
        logic          rel;
        riscv_v_addr_t addr;
        riscv_v_be_t   be;
        riscv_v_data_t data;
    } riscv_v_wr_req_t;

    // Register-address width for a given register count (minimum one bit).
    function automatic int unsigned riscv_v_addr_w(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/riscv_v_rf_mp_wr_merge.sv
// Resolves all write ports against one register address: per-byte hit mask
// and merged byte data, with the highest-index port winning each byte.
module riscv_v_rf_mp_wr_merge #(
    parameter int unsigned NUM_WR_PORTS = 2,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_BYTES   = 16
) (
    input  logic [NUM_WR_PORTS-1:0]                      i_wr_valid,
    input  logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]          i_wr_addr,
    input  logic [NUM_WR_PORTS-1:0][DATA_BYTES-1:0]      i_wr_be,
    input  logic [NUM_WR_PORTS-1:0][DATA_BYTES-1:0][7:0] i_wr_data,
    input  logic [ADDR_W-1:0]                            i_addr,
    output logic [DATA_BYTES-1:0]                        o_hit_c,
    output logic [DATA_BYTES-1:0][7:0]                   o_data_c
);

    // Ascending scan: a later (higher-index) port overwrites earlier hits.
    always_comb begin
        o_hit_c  = '0;
        o_data_c = '0;
        for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
            if (i_wr_valid[p] && (i_wr_addr[p] == i_addr)) begin
                for (int unsigned b = 0; b < DATA_BYTES; b++) begin
                    if (i_wr_be[p][b]) begin
                        o_hit_c[b]  = 1'b1;
                        o_data_c[b] = i_wr_data[p][b];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/riscv_v_rf_mp.sv
// Multi-port vector register file with per-byte writes, optional write-to-read
// bypass, optional registered read, and a per-register busy scoreboard.
module riscv_v_rf_mp
    import riscv_v_rf_mp_pkg::*;
#(
    parameter  int unsigned NUM_REGS     = 32,
    parameter  int unsigned NUM_RD_PORTS = 3,
    parameter  int unsigned NUM_WR_PORTS = 2,
    parameter  int unsigned DATA_BYTES   = RISCV_V_NUM_BYTES_DATA,
    parameter  int unsigned RD_ASYNC     = 1,
    parameter  int unsigned USE_BYPASS   = 1,
    localparam int unsigned ADDR_W       = $clog2(NUM_REGS)
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic [NUM_WR_PORTS-1:0]                      i_wr_valid,
    input  logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]          i_wr_addr,
    input  logic [NUM_WR_PORTS-1:0][DATA_BYTES-1:0]      i_wr_be,
    input  logic [NUM_WR_PORTS-1:0][DATA_BYTES-1:0][7:0] i_wr_data,
    input  logic [NUM_WR_PORTS-1:0]                      i_wr_release,
    input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]          i_rd_addr,
    output logic [NUM_RD_PORTS-1:0][DATA_BYTES-1:0][7:0] o_rd_data,
    output logic [NUM_RD_PORTS-1:0]                      o_rd_busy,
    input  logic                                         i_rsv_valid,
    input  logic [ADDR_W-1:0]                            i_rsv_addr,
    output logic                                         o_rsv_ready,
    output logic [NUM_REGS-1:0]                          o_busy_vec,
    output logic                                         o_wr_conflict,
    input  logic [ADDR_W-1:0]                            i_syn_addr,
    output logic [DATA_BYTES-1:0][7:0]                   o_syn_data
);

    localparam bit BYP = (USE_BYPASS != 0);

    logic [DATA_BYTES-1:0][7:0]                   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]                          r_busy;
    logic [DATA_BYTES-1:0]                        w_wr_hit  [NUM_REGS];
    logic [DATA_BYTES-1:0][7:0]                   w_wr_data [NUM_REGS];
    logic [NUM_RD_PORTS-1:0][DATA_BYTES-1:0][7:0] w_rd_next;
    logic [NUM_REGS-1:0]                          w_rel;
    logic [NUM_REGS-1:0]                          w_busy_nxt;
    logic                                         w_rsv_ready;
    logic                                         w_conflict;

    // Write path: one priority merge per register.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_wr
        riscv_v_rf_mp_wr_merge #(
            .NUM_WR_PORTS (NUM_WR_PORTS),
            .ADDR_W       (ADDR_W),
            .DATA_BYTES   (DATA_BYTES)
        ) u_merge (
            .i_wr_valid (i_wr_valid),
            .i_wr_addr  (i_wr_addr),
            .i_wr_be    (i_wr_be),
            .i_wr_data  (i_wr_data),
            .i_addr     (ADDR_W'(r)),
            .o_hit_c    (w_wr_hit[r]),
            .o_data_c   (w_wr_data[r])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                for (int unsigned b = 0; b < DATA_BYTES; b++) begin
                    if (w_wr_hit[r][b]) begin
                        r_regs[r][b] <= w_wr_data[r][b];
                    end
                end
            end
        end
    end

    // Overlapping byte enables on a shared address; priority still resolves it.
    always_comb begin
        w_conflict = 1'b0;
        for (int unsigned i = 0; i < NUM_WR_PORTS; i++) begin
            for (int unsigned j = i + 1; j < NUM_WR_PORTS; j++) begin
                if (i_wr_valid[i] && i_wr_valid[j] &&
                    (i_wr_addr[i] == i_wr_addr[j]) &&
                    ((i_wr_be[i] & i_wr_be[j]) != '0)) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    assign o_wr_conflict = w_conflict;

    // Read ports: array value, optionally overlaid with this cycle's write bytes.
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [DATA_BYTES-1:0][7:0] w_rd_reg;

        assign w_rd_reg = r_regs[i_rd_addr[p]];

        if (BYP) begin : g_byp
            logic [DATA_BYTES-1:0]      w_byp_hit;
            logic [DATA_BYTES-1:0][7:0] w_byp_data;
            logic [DATA_BYTES-1:0][7:0] w_byp_out;

            riscv_v_rf_mp_wr_merge #(
                .NUM_WR_PORTS (NUM_WR_PORTS),
                .ADDR_W       (ADDR_W),
                .DATA_BYTES   (DATA_BYTES)
            ) u_byp (
                .i_wr_valid (i_wr_valid),
                .i_wr_addr  (i_wr_addr),
                .i_wr_be    (i_wr_be),
                .i_wr_data  (i_wr_data),
                .i_addr     (i_rd_addr[p]),
                .o_hit_c    (w_byp_hit),
                .o_data_c   (w_byp_data)
            );

            always_comb begin
                w_byp_out = w_rd_reg;
                for (int unsigned b = 0; b < DATA_BYTES; b++) begin
                    if (w_byp_hit[b]) begin
                        w_byp_out[b] = w_byp_data[b];
                    end
                end
            end

            assign w_rd_next[p] = w_byp_out;
        end else begin : g_nobyp
            assign w_rd_next[p] = w_rd_reg;
        end

        assign o_rd_busy[p] = r_busy[i_rd_addr[p]] & ~(BYP & w_rel[i_rd_addr[p]]);
    end

    // Registered read samples the bypassed (write-first) or raw (read-first) value.
    if (RD_ASYNC != 0) begin : g_rd_async
        assign o_rd_data = w_rd_next;
    end else begin : g_rd_sync
        logic [NUM_RD_PORTS-1:0][DATA_BYTES-1:0][7:0] r_rd_data;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_rd_data <= '0;
            end else begin
                r_rd_data <= w_rd_next;
            end
        end

        assign o_rd_data = r_rd_data;
    end

    assign o_syn_data = r_regs[i_syn_addr];

    // Scoreboard: release decode, reservation accept, next busy state.
    always_comb begin
        w_rel = '0;
        for (int unsigned p = 0; p < NUM_WR_PORTS; p++) begin
            if (i_wr_valid[p] && i_wr_release[p]) begin
                w_rel[i_wr_addr[p]] = 1'b1;
            end
        end
    end

    assign w_rsv_ready = ~r_busy[i_rsv_addr] | w_rel[i_rsv_addr];

    always_comb begin
        w_busy_nxt = r_busy & ~w_rel;
        if (i_rsv_valid && w_rsv_ready) begin
            w_busy_nxt[i_rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_rsv_ready = w_rsv_ready;
    assign o_busy_vec  = r_busy;

endmodule

// File: doc/riscv_v_rf_mp.md
Name: riscv_v_rf_mp

Overview:
Multi-port vector register file for the RISC-V V datapath, generalising the single-write/dual-read vector RF. Supports configurable register count and read/write port counts, and per-byte write enables with fixed port priority. Provides optional write-to-read bypass, optional synchronous read, and a per-register busy scoreboard (reserve/release handshake). This scoreboard lets issue logic stall on pending vector writes. Sits between vector decode/issue and the vector lanes; also exposes a debug/synthesis read port.

Parameters:
NUM_REGS, 32, number of vector registers (power of 2, >=2)
NUM_RD_PORTS, 3, read ports (>=1)
NUM_WR_PORTS, 2, write ports (>=1)
DATA_BYTES, RISCV_V_NUM_BYTES_DATA, bytes per vector register
RD_ASYNC, 1, 1 = combinational read, 0 = registered read (1-cycle latency)
USE_BYPASS, 1, 1 = same-cycle write data forwarded to reads
Derived: ADDR_W = $clog2(NUM_REGS)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
wr_valid  in  NUM_WR_PORTS  write request per port
wr_addr  in  NUM_WR_PORTS x ADDR_W  write register per port
wr_be  in  NUM_WR_PORTS x DATA_BYTES  byte enables per port
wr_data  in  NUM_WR_PORTS x 8*DATA_BYTES  write data per port
wr_release  in  NUM_WR_PORTS  clear busy of wr_addr[p]; qualified by wr_valid[p]
rd_addr  in  NUM_RD_PORTS x ADDR_W  read register per port
rd_data  out  NUM_RD_PORTS x 8*DATA_BYTES  read data
rd_busy  out  NUM_RD_PORTS  target register has pending write
rsv_valid  in  1  reservation request
rsv_addr  in  ADDR_W  register to reserve
rsv_ready  out  1  reservation accepted this cycle
busy_vec  out  NUM_REGS  scoreboard state
wr_conflict  out  1  >=2 valid write ports target same register with overlapping byte enables
syn_addr  in  ADDR_W  debug read address
syn_data  out  8*DATA_BYTES  regs[syn_addr], combinational, no bypass

Behaviour:
- Reset (async assert, released on clk edge): all registers = 0, busy_vec = 0, registered rd_data = 0; rsv_ready high once rst deasserts (no busy). Reset mid-operation discards in-flight writes/reservations.
- Write: at posedge, for register r, byte b: new value = wr_data[p].byte[b] of the HIGHEST-index p with wr_valid[p] & wr_addr[p]==r & wr_be[p][b]; otherwise hold. Bytes with no enable unchanged.
- wr_conflict: combinational, high when two valid ports share wr_addr and (wr_be[i] & wr_be[j]) != 0. Informational only; priority rule still applies.
- Read, RD_ASYNC=1: rd_data[p] = regs[rd_addr[p]]. USE_BYPASS=1: each byte is replaced by the winning write byte (same priority rule) for that cycle's writes.
- Read, RD_ASYNC=0: rd_data[p] registered. Next cycle it holds the value sampled at the edge: pre-write value if USE_BYPASS=0, post-write (write-first) value if USE_BYPASS=1.
- Scoreboard:
  - rel[r] = any p with wr_valid[p] & wr_release[p] & wr_addr[p]==r.
  - rsv_ready = !busy[rsv_addr] | rel[rsv_addr].
  - Reservation takes effect only when rsv_valid & rsv_ready.
  - Next busy[r] = (rsv_valid & rsv_ready & rsv_addr==r) | (busy[r] & !rel[r]). Set wins over simultaneous release.
  - Release of a non-busy register is a no-op.
- rd_busy[p] = busy[rd_addr[p]] & !(USE_BYPASS & rel[rd_addr[p]]). With bypass, a releasing write's data is consumable in the same cycle.
- No backpressure on writes; every valid write completes in one cycle.

Decomposition:
- riscv_v_pkg: RISCV_V_NUM_BYTES_DATA (existing), riscv_v_data_t (existing, with .Byte[] view), parametrised-width address types derived from NUM_REGS.
- Sub-module riscv_v_rf_wr_merge (combinational): given all write ports and a target address, outputs per-byte hit mask and merged data by port priority. Used by the write path and by each bypass port.
- Scoreboard stays inline (small); no FSM beyond per-register busy flops.

Test Plan:
- Reset then read v5 on all ports -> rd_data = 0, busy_vec = 0, rsv_ready = 1.
- P0 writes v3 be=0xFFFF data=0x11..11; P1 writes v3 be=0x000F data=0x22..22 same cycle -> wr_conflict = 1; v3 bytes 0-3 = 0x22, bytes 4-15 = 0x11.
- RD_ASYNC=1, USE_BYPASS=1: P0 writes v7 be=0x00FF data=0xAA.., rd_addr[0]=7 same cycle (old v7 = 0) -> rd_data[0] low 8 bytes 0xAA, high 8 bytes 0x00. Repeat with USE_BYPASS=0 -> all 0 until next cycle.
- rsv v9 -> busy_vec[9]=1, rd_busy on port reading v9 = 1; second rsv v9 -> rsv_ready=0, still busy. P1 write v9 with release -> rsv_ready=1 that cycle; rd_busy=0 (bypass); busy_vec[9]=0 next cycle.
- Simultaneous rsv v4 and release-write v4 while busy -> busy_vec[4] remains 1.
- RD_ASYNC=0: write v2=0x55.. at edge N with rd_addr=2 -> at N+1 rd_data = 0x55.. (bypass) / previous v2 (no bypass). Assert rst mid-stream -> rd_data, busy_vec, all regs 0 immediately.
